// File: rtl/cla_pipe_adder_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor.
package cla_pipe_adder_pkg;

  // Operation select on the sub port.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // First-level lookahead group width.
  localparam int GRP = 4;

  // Pipeline depth: one stage per SEG-bit segment.
  function automatic int calc_nstg(input int w, input int seg);
    return w / seg;
  endfunction

  // Legal geometry: whole segments, each made of whole 4-bit groups.
  function automatic bit cfg_ok(input int w, input int seg);
    return (seg > 0) && (seg % GRP == 0) && (w >= seg) && (w % seg == 0);
  endfunction

endpackage

// File: rtl/cla_seg.sv
// Combinational SEG-bit carry-lookahead slice: 4-bit group G/P, then a
// second lookahead level across groups. Carries are formed as flat
// sum-of-products so no ripple path exists inside the slice.
module cla_seg
  import cla_pipe_adder_pkg::*;
#(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co
);
  localparam int NG = SEG / GRP;

  logic [SEG-1:0] g, p, c;
  logic [NG-1:0]  gg, gp;
  logic [NG:0]    gc;

  assign g = a & b;
  assign p = a ^ b;

  // Group generate / propagate for each 4-bit group.
  always_comb begin
    gg = '0;
    gp = '0;
    for (int j = 0; j < NG; j++) begin
      gg[j] = g[j*GRP+3]
            | (p[j*GRP+3] & g[j*GRP+2])
            | (p[j*GRP+3] & p[j*GRP+2] & g[j*GRP+1])
            | (p[j*GRP+3] & p[j*GRP+2] & p[j*GRP+1] & g[j*GRP]);
      gp[j] = &p[j*GRP +: GRP];
    end
  end

  // Second-level lookahead: carry into every group straight from ci.
  always_comb begin
    logic acc, run;
    acc = 1'b0;
    run = 1'b1;
    gc  = '0;
    for (int j = 0; j <= NG; j++) begin
      acc = 1'b0;
      run = 1'b1;
      for (int i = j - 1; i >= 0; i--) begin
        acc = acc | (run & gg[i]);
        run = run & gp[i];
      end
      gc[j] = acc | (run & ci);
    end
  end

  // In-group lookahead: carry into each bit from its group carry-in.
  always_comb begin
    logic acc, run;
    acc = 1'b0;
    run = 1'b1;
    c   = '0;
    for (int j = 0; j < NG; j++) begin
      for (int k = 0; k < GRP; k++) begin
        acc = 1'b0;
        run = 1'b1;
        for (int i = k - 1; i >= 0; i--) begin
          acc = acc | (run & g[j*GRP+i]);
          run = run & p[j*GRP+i];
        end
        c[j*GRP+k] = acc | (run & gc[j]);
      end
    end
  end

  assign s  = p ^ c;
  assign co = gc[NG];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor. One SEG-bit segment is
// resolved per stage; the carry is registered between stages, unresolved
// operand segments ride along skewed, finished sum segments are delayed
// so a beat leaves in one piece. A single global advance freezes the
// whole pipe under back-pressure.
module cla_pipe_adder
  import cla_pipe_adder_pkg::*;
#(
  parameter int W   = 32,
  parameter int SEG = 8,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         ovf
);
  localparam int NSTG = calc_nstg(W, SEG);

  if (!cfg_ok(W, SEG)) begin : g_cfg_chk
    $error("cla_pipe_adder: W must be a multiple of SEG, SEG a multiple of 4");
  end

  logic         adv;
  logic [W-1:0] b_eff;
  logic [NSTG:0] vld_pipe;   // [0] = incoming beat, [k] = after stage k-1
  logic [NSTG:0] car;        // [0] = entry carry, [k] = carry out of stage k-1
  logic         sa_q, sb_q;
  logic [W-1:0] raw;

  assign adv         = !out_valid || out_ready;
  assign in_ready    = adv;
  assign b_eff       = (sub == OP_SUB) ? ~b : b;
  assign vld_pipe[0] = in_valid;
  assign car[0]      = (sub == OP_SUB) ? 1'b1 : cin;

  // Skewed operand segments still waiting for their stage.
  for (genvar k = 1; k < NSTG; k++) begin : g_opr
    logic [W-1:k*SEG] ua_q, ub_q;
    logic [W-1:k*SEG] ua_d, ub_d;
    if (k == 1) begin : g_first
      assign ua_d = a[W-1:SEG];
      assign ub_d = b_eff[W-1:SEG];
    end else begin : g_next
      assign ua_d = g_opr[k-1].ua_q[W-1:k*SEG];
      assign ub_d = g_opr[k-1].ub_q[W-1:k*SEG];
    end
    // Operand skew register, frozen with the rest of the pipe.
    always_ff @(posedge clk) begin
      if (rst) begin
        ua_q <= '0;
        ub_q <= '0;
      end else if (adv) begin
        ua_q <= ua_d;
        ub_q <= ub_d;
      end
    end
  end

  // One lookahead slice per stage plus its carry/valid/sum registers.
  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    logic [SEG-1:0]         sa, sb, ss;
    logic                   co, v_q, c_q;
    logic [(k+1)*SEG-1:0]   lo_d, lo_q;

    if (k == 0) begin : g_in
      assign sa   = a[SEG-1:0];
      assign sb   = b_eff[SEG-1:0];
      assign lo_d = ss;
    end else begin : g_mid
      assign sa   = g_opr[k].ua_q[k*SEG +: SEG];
      assign sb   = g_opr[k].ub_q[k*SEG +: SEG];
      assign lo_d = {ss, g_stg[k-1].lo_q};
    end

    cla_seg #(.SEG(SEG)) u_seg (
      .a  (sa),
      .b  (sb),
      .ci (car[k]),
      .s  (ss),
      .co (co)
    );

    // Stage register: valid, carry and the sum segments finished so far.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q  <= 1'b0;
        c_q  <= 1'b0;
        lo_q <= '0;
      end else if (adv) begin
        v_q  <= vld_pipe[k];
        c_q  <= co;
        lo_q <= lo_d;
      end
    end

    assign vld_pipe[k+1] = v_q;
    assign car[k+1]      = c_q;
  end

  // Operand sign bits aligned with the last stage for overflow detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa_q <= 1'b0;
      sb_q <= 1'b0;
    end else if (adv) begin
      sa_q <= g_stg[NSTG-1].sa[SEG-1];
      sb_q <= g_stg[NSTG-1].sb[SEG-1];
    end
  end

  assign raw       = g_stg[NSTG-1].lo_q;
  assign out_valid = vld_pipe[NSTG];
  assign cout      = car[NSTG];
  assign ovf       = (sa_q == sb_q) && (raw[W-1] != sa_q);

  // Optional signed clamp on overflow, otherwise pass the wrapped sum.
  always_comb begin
    s = raw;
    if (SAT && ovf)
      s = sa_q ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: three instances in lockstep (32/8 wrap,
// 32/8 saturate, 16/4 saturate) sharing inputs and out_ready.
module tb_cla_pipe_adder;

  logic        clk = 1'b0;
  logic        rst, in_valid, cin, sub, out_ready;
  logic [31:0] a, b;

  logic        rdy0, rdy1, rdy2, ov0, ov1, ov2;
  logic [31:0] s0, s1;
  logic [15:0] s2;
  logic        co0, co1, co2, of0, of1, of2;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] s0; logic c0; logic o0;
    logic [31:0] s1; logic c1; logic o1;
    logic [15:0] s2; logic c2; logic o2;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  cla_pipe_adder #(.W(32), .SEG(8), .SAT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov0), .out_ready(out_ready), .s(s0), .cout(co0), .ovf(of0));

  cla_pipe_adder #(.W(32), .SEG(8), .SAT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov1), .out_ready(out_ready), .s(s1), .cout(co1), .ovf(of1));

  cla_pipe_adder #(.W(16), .SEG(4), .SAT(1'b1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
    .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub),
    .out_valid(ov2), .out_ready(out_ready), .s(s2), .cout(co2), .ovf(of2));

  function automatic logic [65:0] ref_calc(input logic [63:0] x, input logic [63:0] y,
                                           input logic ci, input logic sb,
                                           input int w, input bit sat);
    logic [63:0] mask, ye, r;
    logic [64:0] full;
    logic        c, ov, sx, sy;
    mask = (64'd1 << w) - 64'd1;
    ye   = (sb ? ~y : y) & mask;
    full = {1'b0, x & mask} + {1'b0, ye} + {64'd0, (sb ? 1'b1 : ci)};
    r    = full[63:0] & mask;
    c    = full[w];
    sx   = x[w-1];
    sy   = ye[w-1];
    ov   = (sx == sy) && (r[w-1] != sx);
    if (sat && ov) r = sx ? (64'd1 << (w - 1)) : (mask >> 1);
    return {ov, c, r};
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h0000_7FFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic run_beat(input logic [31:0] x, input logic [31:0] y,
                          input logic ci, input logic sb, output logic early);
    @(posedge clk); #1;
    in_valid = 1'b1; a = x; b = y; cin = ci; sub = sb; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    early = ov0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; a = '1; b = '1; cin = 1'b1; sub = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({ov0, s0, co0, of0} !== {1'b0, 32'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b s=%h c=%b o=%b, want v=0 s=0 c=0 o=0", ov0, s0, co0, of0);
    end
    n_chk++;
    if ({ov1, ov2, s2} !== {1'b0, 1'b0, 16'h0}) begin
      n_fail++;
      $display("FAIL reset_outputs_other: got v1=%b v2=%b s2=%h, want 0 0 0", ov1, ov2, s2);
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if ({rdy0, rdy1, rdy2, ov0} !== 4'b1110) begin
      n_fail++;
      $display("FAIL reset_in_ready: got rdy=%b%b%b v=%b, want rdy=111 v=0", rdy0, rdy1, rdy2, ov0);
    end
  endtask

  task automatic test_carry();
    logic early;
    run_beat(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, early);
    n_chk++;
    if (early !== 1'b0) begin
      n_fail++;
      $display("FAIL carry_latency_early: got out_valid=%b at cycle 3, want 0", early);
    end
    n_chk++;
    if ({ov0, s0, co0, of0} !== {1'b1, 32'h0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL carry_wrap: got v=%b s=%h c=%b o=%b, want v=1 s=00000000 c=1 o=0", ov0, s0, co0, of0);
    end
    n_chk++;
    if ({ov1, s1, co1, of1} !== {1'b1, 32'h0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL carry_sat: got v=%b s=%h c=%b o=%b, want v=1 s=00000000 c=1 o=0", ov1, s1, co1, of1);
    end
    n_chk++;
    if ({ov2, s2, co2, of2} !== {1'b1, 16'h0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL carry_w16: got v=%b s=%h c=%b o=%b, want v=1 s=0000 c=1 o=0", ov2, s2, co2, of2);
    end
    @(posedge clk); #1;
    n_chk++;
    if (ov0 !== 1'b0) begin
      n_fail++;
      $display("FAIL carry_bubble: got out_valid=%b after single beat, want 0", ov0);
    end
    run_beat(32'h1, 32'h1, 1'b1, 1'b0, early);
    n_chk++;
    if ({ov0, s0, co0, of0} !== {1'b1, 32'h3, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL add_cin: got v=%b s=%h c=%b o=%b, want v=1 s=00000003 c=0 o=0", ov0, s0, co0, of0);
    end
  endtask

  task automatic test_sub();
    logic early;
    run_beat(32'h5, 32'h7, 1'b1, 1'b1, early);
    n_chk++;
    if ({ov0, s0, co0, of0} !== {1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL sub_borrow: got v=%b s=%h c=%b o=%b, want v=1 s=fffffffe c=0 o=0", ov0, s0, co0, of0);
    end
    n_chk++;
    if ({s2, co2, of2} !== {16'hFFFE, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL sub_borrow_w16: got s=%h c=%b o=%b, want s=fffe c=0 o=0", s2, co2, of2);
    end
    run_beat(32'h8000_0000, 32'h1, 1'b0, 1'b1, early);
    n_chk++;
    if ({ov0, s0, co0, of0} !== {1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL sub_ovf_wrap: got v=%b s=%h c=%b o=%b, want v=1 s=7fffffff c=1 o=1", ov0, s0, co0, of0);
    end
    n_chk++;
    if ({s1, of1} !== {32'h8000_0000, 1'b1}) begin
      n_fail++;
      $display("FAIL sub_ovf_sat: got s=%h o=%b, want s=80000000 o=1", s1, of1);
    end
  endtask

  task automatic test_sat();
    logic early;
    run_beat(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, early);
    n_chk++;
    if ({ov1, s1, co1, of1} !== {1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL sat_pos: got v=%b s=%h c=%b o=%b, want v=1 s=7fffffff c=0 o=1", ov1, s1, co1, of1);
    end
    n_chk++;
    if ({s0, of0} !== {32'h8000_0000, 1'b1}) begin
      n_fail++;
      $display("FAIL wrap_pos: got s=%h o=%b, want s=80000000 o=1", s0, of0);
    end
    n_chk++;
    if ({s2, co2, of2} !== {16'h0000, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL sat_pos_w16: got s=%h c=%b o=%b, want s=0000 c=1 o=0", s2, co2, of2);
    end
    run_beat(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, early);
    n_chk++;
    if ({ov1, s1, co1, of1} !== {1'b1, 32'h8000_0000, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL sat_neg: got v=%b s=%h c=%b o=%b, want v=1 s=80000000 c=1 o=1", ov1, s1, co1, of1);
    end
    n_chk++;
    if ({s0, of0} !== {32'h7FFF_FFFF, 1'b1}) begin
      n_fail++;
      $display("FAIL wrap_neg: got s=%h o=%b, want s=7fffffff o=1", s0, of0);
    end
  endtask

  task automatic test_reset_mid();
    logic early;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 32'd10 + i; b = 32'd20; cin = 1'b0; sub = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_chk++;
      if ({ov0, ov1, ov2} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_mid_flush cycle %0d: got out_valid=%b%b%b, want 000", i, ov0, ov1, ov2);
      end
      @(posedge clk); #1;
    end
    run_beat(32'h2, 32'h3, 1'b0, 1'b0, early);
    n_chk++;
    if ({early, ov0, s0} !== {1'b0, 1'b1, 32'h5}) begin
      n_fail++;
      $display("FAIL reset_mid_new: got early=%b v=%b s=%h, want early=0 v=1 s=00000005", early, ov0, s0);
    end
  endtask

  task automatic test_stream(input int n, input int mode, input string tag);
    int          sent = 0, got = 0, cyc = 0;
    logic [31:0] x, y;
    logic        ci, sb, hold;
    exp_t        e, hv;
    logic [65:0] r0, r1, r2;
    hold = 1'b0;
    hv   = '0;
    q.delete();
    x = rnd32(); y = rnd32(); ci = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    while ((got < n) && (cyc < n * 8 + 100)) begin
      if (mode == 0) out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      else           out_ready = ($urandom_range(0, 3) != 0);
      in_valid = (sent < n) && ((mode == 0) || ($urandom_range(0, 4) != 0));
      a = x; b = y; cin = ci; sub = sb;
      #1;
      n_chk++;
      if ({rdy0, rdy1, rdy2} !== {3{!ov0 || out_ready}}) begin
        n_fail++;
        $display("FAIL %s_in_ready cycle %0d: got %b%b%b, want %b", tag, cyc, rdy0, rdy1, rdy2, !ov0 || out_ready);
      end
      if (hold) begin
        n_chk++;
        if ({ov0, ov1, ov2} !== 3'b111 || s0 !== hv.s0 || co0 !== hv.c0 || of0 !== hv.o0 ||
            s1 !== hv.s1 || s2 !== hv.s2) begin
          n_fail++;
          $display("FAIL %s_hold cycle %0d: got v=%b%b%b s0=%h s1=%h s2=%h, want held s0=%h s1=%h s2=%h",
                   tag, cyc, ov0, ov1, ov2, s0, s1, s2, hv.s0, hv.s1, hv.s2);
        end
      end
      if (ov0 && out_ready) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL %s_spurious cycle %0d: got result s0=%h with nothing outstanding, want none", tag, cyc, s0);
        end else begin
          e = q.pop_front();
          if ({ov1, ov2} !== 2'b11 || s0 !== e.s0 || co0 !== e.c0 || of0 !== e.o0 ||
              s1 !== e.s1 || co1 !== e.c1 || of1 !== e.o1 ||
              s2 !== e.s2 || co2 !== e.c2 || of2 !== e.o2) begin
            n_fail++;
            $display("FAIL %s_result #%0d: got v=%b%b s0=%h/%b%b s1=%h/%b%b s2=%h/%b%b, want v=11 s0=%h/%b%b s1=%h/%b%b s2=%h/%b%b",
                     tag, got, ov1, ov2, s0, co0, of0, s1, co1, of1, s2, co2, of2,
                     e.s0, e.c0, e.o0, e.s1, e.c1, e.o1, e.s2, e.c2, e.o2);
          end
        end
        got++;
      end
      hold = ov0 && !out_ready;
      hv.s0 = s0; hv.c0 = co0; hv.o0 = of0; hv.s1 = s1; hv.s2 = s2;
      if (in_valid && rdy0) begin
        r0 = ref_calc({32'd0, x}, {32'd0, y}, ci, sb, 32, 1'b0);
        r1 = ref_calc({32'd0, x}, {32'd0, y}, ci, sb, 32, 1'b1);
        r2 = ref_calc({48'd0, x[15:0]}, {48'd0, y[15:0]}, ci, sb, 16, 1'b1);
        e.s0 = r0[31:0]; e.c0 = r0[64]; e.o0 = r0[65];
        e.s1 = r1[31:0]; e.c1 = r1[64]; e.o1 = r1[65];
        e.s2 = r2[15:0]; e.c2 = r2[64]; e.o2 = r2[65];
        q.push_back(e);
        sent++;
        x = rnd32(); y = rnd32(); ci = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_chk++;
    if (got != n || q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_count: got %0d results with %0d outstanding, want %0d and 0", tag, got, q.size(), n);
    end
  endtask

  initial begin
    test_reset();
    test_carry();
    test_sub();
    test_sat();
    test_stream(10, 0, "back_to_back");
    test_reset_mid();
    test_stream(10000, 1, "random");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
